// File: rtl/player_pkg.sv
// Shared types and widths for the player ship block.
// Contents:
//   LIVES_W        width of the lives counter
//   POS_W          width of horizontal pixel positions
//   player_state_e one-hot ship controller state
package player_pkg;

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned POS_W   = 10;

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StLeft  = 5'b00010,
    StRight = 5'b00100,
    StHit   = 5'b01000,
    StDead  = 5'b10000
  } player_state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider producing a one-cycle tick every DIV_P cycles.
// The counter runs 0..DIV_P-1 and ticks on the wrap cycle; only reset clears it.
// Ports:
//   clk_i    clock
//   reset_ni asynchronous active-low reset
//   tick_o   high for one cycle when the counter wraps
module tick_divider #(
  parameter int unsigned DIV_P = 416667
) (
  input  logic clk_i,
  input  logic reset_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV_P > 1) ? $clog2(DIV_P) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV_P - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_ship.sv
// Player ship controller: one-hot FSM, clamped stepped motion, lives, fire cooldown and
// pause/resume on hit or death.
// Optional feature: define PLAYER_SHIP_FLASH_EN to flash the ship while in HIT
// (visible toggles every 16 move ticks, starting visible).
// Ports:
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   move_left_i/right_i     button levels
//   shoot_i                 shoot/resume button level (rising edge used)
//   hit_i, level_clear_i    single-cycle event pulses
//   alive_o, lives_o        lives status
//   pos_left_o, pos_right_o ship horizontal extent
//   fire_o                  one-cycle bullet launch pulse
//   paused_o, visible_o     game freeze / draw enable
//   state_o                 one-hot present state
module player_ship
  import player_pkg::*;
#(
  parameter int unsigned LIVES_P    = 3,
  parameter int unsigned SCREEN_W_P = 640,
  parameter int unsigned SHIP_W_P   = 32,
  parameter int unsigned START_X_P  = 304,
  parameter int unsigned STEP_P     = 2,
  parameter int unsigned MOVE_DIV_P = 416667,
  parameter int unsigned COOLDOWN_P = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               move_left_i,
  input  logic               move_right_i,
  input  logic               shoot_i,
  input  logic               hit_i,
  input  logic               level_clear_i,
  output logic               alive_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic [POS_W-1:0]   pos_left_o,
  output logic [POS_W-1:0]   pos_right_o,
  output logic               fire_o,
  output logic               paused_o,
  output logic               visible_o,
  output logic [4:0]         state_o
);

  localparam int unsigned CoolW = $clog2(COOLDOWN_P + 1);
  localparam logic [POS_W-1:0]   PosMax    = POS_W'(SCREEN_W_P - SHIP_W_P);
  localparam logic [POS_W-1:0]   StartX    = POS_W'(START_X_P);
  localparam logic [POS_W-1:0]   Step      = POS_W'(STEP_P);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_P);
  localparam logic [CoolW-1:0]   CoolLoad  = CoolW'(COOLDOWN_P);

  player_state_e      state_q, state_d;
  player_state_e      move_state;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [CoolW-1:0]   cool_q, cool_d;
  logic               shoot_q;
  logic               fire_q, fire_d;
  logic               tick;
  logic               shoot_edge;

  tick_divider #(
    .DIV_P(MOVE_DIV_P)
  ) u_tick (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .tick_o  (tick)
  );

  assign shoot_edge = shoot_i & ~shoot_q;

  always_comb begin
    if (move_left_i && !move_right_i) begin
      move_state = StLeft;
    end else if (move_right_i && !move_left_i) begin
      move_state = StRight;
    end else begin
      move_state = StIdle;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    pos_d   = pos_q;
    fire_d  = 1'b0;
    // Cooldown drains on every move tick regardless of state; later branches override.
    cool_d  = (tick && cool_q != '0) ? cool_q - CoolW'(1) : cool_q;

    unique case (state_q)
      StIdle, StLeft, StRight: begin
        // Priority: hit, then level clear, then normal motion and fire.
        if (hit_i) begin
          lives_d = lives_q - LIVES_W'(1);
          state_d = (lives_q == LIVES_W'(1)) ? StDead : StHit;
        end else if (level_clear_i) begin
          pos_d   = StartX;
          cool_d  = '0;
          state_d = StIdle;
        end else begin
          state_d = move_state;
          if (tick && state_q == StLeft) begin
            pos_d = (pos_q < Step) ? '0 : pos_q - Step;
          end else if (tick && state_q == StRight) begin
            // Widened sum so the saturation test cannot wrap.
            pos_d = ({1'b0, pos_q} + {1'b0, Step} > {1'b0, PosMax}) ? PosMax : pos_q + Step;
          end
          if (shoot_edge && cool_q == '0) begin
            fire_d = 1'b1;
            cool_d = CoolLoad;
          end
        end
      end
      StHit: begin
        if (shoot_edge) begin
          state_d = StIdle;
          cool_d  = '0;
        end
      end
      StDead: begin
        if (shoot_edge) begin
          state_d = StIdle;
          lives_d = LivesInit;
          pos_d   = StartX;
          cool_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      lives_q <= LivesInit;
      pos_q   <= StartX;
      cool_q  <= '0;
      shoot_q <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      pos_q   <= pos_d;
      cool_q  <= cool_d;
      shoot_q <= shoot_i;
      fire_q  <= fire_d;
    end
  end

`ifdef PLAYER_SHIP_FLASH_EN
  logic [3:0] flash_cnt_q;
  logic       flash_q;

  // Held at "visible, count 0" outside HIT so every entry starts visible.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      flash_cnt_q <= '0;
      flash_q     <= 1'b1;
    end else if (state_q != StHit) begin
      flash_cnt_q <= '0;
      flash_q     <= 1'b1;
    end else if (tick) begin
      flash_cnt_q <= flash_cnt_q + 4'd1;
      if (flash_cnt_q == 4'd15) begin
        flash_q <= ~flash_q;
      end
    end
  end

  assign visible_o = (state_q == StDead) ? 1'b0 : (state_q == StHit) ? flash_q : 1'b1;
`else
  assign visible_o = (state_q != StDead);
`endif

  assign alive_o     = (lives_q != '0);
  assign lives_o     = lives_q;
  assign pos_left_o  = pos_q;
  assign pos_right_o = pos_q + POS_W'(SHIP_W_P - 1);
  assign fire_o      = fire_q;
  assign paused_o    = (state_q == StHit) || (state_q == StDead);
  assign state_o     = state_q;

endmodule

// File: tb/tb_player_ship.sv
// Self-checking bench for player_ship: a behavioural model predicts the outputs after each
// clock edge and queues them; a negedge monitor pops and compares against the DUT.
module tb_player_ship;

  localparam int LivesP = 3;
  localparam int ScreenW = 640;
  localparam int ShipW = 32;
  localparam int StartX = 304;
  localparam int StepP = 2;
  localparam int DivP = 4;
  localparam int CoolP = 8;
  localparam int PosMax = ScreenW - ShipW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ml = 1'b0, mr = 1'b0, sh = 1'b0, hit = 1'b0, lc = 1'b0;
  logic       alive, fire, paused, visible;
  logic [2:0] lives;
  logic [9:0] pos_left, pos_right;
  logic [4:0] state;

  always #5 clk = ~clk;

  player_ship #(
    .LIVES_P   (LivesP),
    .SCREEN_W_P(ScreenW),
    .SHIP_W_P  (ShipW),
    .START_X_P (StartX),
    .STEP_P    (StepP),
    .MOVE_DIV_P(DivP),
    .COOLDOWN_P(CoolP)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .move_left_i  (ml),
    .move_right_i (mr),
    .shoot_i      (sh),
    .hit_i        (hit),
    .level_clear_i(lc),
    .alive_o      (alive),
    .lives_o      (lives),
    .pos_left_o   (pos_left),
    .pos_right_o  (pos_right),
    .fire_o       (fire),
    .paused_o     (paused),
    .visible_o    (visible),
    .state_o      (state)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int fire_seen = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (fire === 1'b1) fire_seen++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int cyc;
    int st;
    int lives;
    int pos;
    int fire;
    int paused;
    int vis;
    int alive;
  } exp_t;

  exp_t q[$];

  // Model state: mode 0 idle, 1 left, 2 right, 3 hit, 4 dead.
  int m_mode, m_lives, m_pos, m_cool, m_k, m_prev, m_fire;

  task automatic reset_model();
    m_mode = 0; m_lives = LivesP; m_pos = StartX; m_cool = 0;
    m_k = 0; m_prev = 0; m_fire = 0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit   tick, edge_s;
    int   cool_before;
    exp_t e;
    tick = ((m_k % DivP) == DivP - 1);
    m_k++;
    edge_s = sh && (m_prev == 0);
    m_prev = sh;
    m_fire = 0;
    cool_before = m_cool;
    if (tick && m_cool > 0) m_cool--;
    if (m_mode <= 2) begin
      if (hit) begin
        m_lives--;
        m_mode = (m_lives > 0) ? 3 : 4;
      end else if (lc) begin
        m_pos = StartX; m_cool = 0; m_mode = 0;
      end else begin
        if (tick && m_mode == 1) m_pos = (m_pos - StepP < 0) ? 0 : m_pos - StepP;
        if (tick && m_mode == 2) m_pos = (m_pos + StepP > PosMax) ? PosMax : m_pos + StepP;
        if (edge_s && cool_before == 0) begin
          m_fire = 1; m_cool = CoolP;
        end
        m_mode = (ml && !mr) ? 1 : (mr && !ml) ? 2 : 0;
      end
    end else if (edge_s) begin
      if (m_mode == 4) begin
        m_lives = LivesP; m_pos = StartX;
      end
      m_mode = 0; m_cool = 0;
    end
    e.cyc = cyc_cnt + 1;
    e.st = 1 << m_mode;
    e.lives = m_lives;
    e.pos = m_pos;
    e.fire = m_fire;
    e.paused = (m_mode >= 3) ? 1 : 0;
`ifdef PLAYER_SHIP_FLASH_EN
    e.vis = (m_mode == 3) ? -1 : ((m_mode != 4) ? 1 : 0);
`else
    e.vis = (m_mode != 4) ? 1 : 0;
`endif
    e.alive = (m_lives != 0) ? 1 : 0;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      chk("state", int'(state), e.st);
      chk("lives", int'(lives), e.lives);
      chk("pos_left", int'(pos_left), e.pos);
      chk("pos_right", int'(pos_right), e.pos + ShipW - 1);
      chk("fire", int'(fire), e.fire);
      chk("paused", int'(paused), e.paused);
      if (e.vis >= 0) chk("visible", int'(visible), e.vis);
      chk("alive", int'(alive), e.alive);
    end
  end

  // Called at a negedge: drive inputs, predict the next edge, advance to the next negedge.
  task automatic step(input bit l, input bit r, input bit s, input bit h, input bit c);
    ml = l; mr = r; sh = s; hit = h; lc = c;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 1);
    chk({tag, "_lives"}, int'(lives), LivesP);
    chk({tag, "_pos"}, int'(pos_left), StartX);
    chk({tag, "_fire"}, int'(fire), 0);
    chk({tag, "_paused"}, int'(paused), 0);
    chk({tag, "_visible"}, int'(visible), 1);
    chk({tag, "_alive"}, int'(alive), 1);
  endtask

  task automatic drain();
    #1;
    if (q.size() != 0) begin
      chk("queue_drained", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic random_run(input int n);
    bit l, r, s;
    l = 0; r = 0; s = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) l = ~l;
      if ($urandom_range(0, 15) == 0) r = ~r;
      if ($urandom_range(0, 5) == 0) s = ~s;
      step(l, r, s, $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
    end
  endtask

  int f0;

  initial begin
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Ten move ticks holding left from the start position.
    for (int i = 0; i < 10 * DivP; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("left10_pos_left", int'(pos_left), 284);
    chk("left10_pos_right", int'(pos_right), 315);
    chk("left10_state", int'(state), 2);

    // Both buttons: idle, position constant.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Cooldown: second edge one tick later dropped, third after eight ticks fires.
    idle(2);
    f0 = fire_seen;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(DivP);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(10 * DivP);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("cooldown_fire_pulses", fire_seen - f0, 2);

    // Three hits with resumes.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hit2_lives", int'(lives), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dead_lives", int'(lives), 0);
    chk("dead_alive", int'(alive), 0);
    chk("dead_visible", int'(visible), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("revive_lives", int'(lives), LivesP);
    chk("revive_pos", int'(pos_left), StartX);
    idle(2);

    // Hit and shoot edge together, then a second hit while paused.
    f0 = fire_seen;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hit_in_hit_lives", int'(lives), LivesP - 1);
    chk("hit_shoot_no_fire", fire_seen - f0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Walk left a while, then level clear.
    for (int i = 0; i < 40 * DivP; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lclear_pos", int'(pos_left), StartX);
    chk("lclear_lives", int'(lives), LivesP - 1);

    // Hold right long enough to saturate.
    for (int i = 0; i < 170 * DivP; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("right_sat_pos", int'(pos_left), PosMax);
    chk("right_sat_right", int'(pos_right), ScreenW - 1);

    random_run(3000);

    // Asynchronous reset mid-run.
    drain();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    ml = 0; mr = 0; sh = 0; hit = 0; lc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();

    random_run(2000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
